// File: rtl/vga_dec_pkg.sv
`default_nettype none
//==============================================================================
// Package : vga_dec_pkg
// Brief   : Shared types and constants for the VGA sync decoder.
// Rev     : 1.0  initial release
//==============================================================================
package vga_dec_pkg;

    localparam int               c_CNT_W      = 12;
    localparam logic [c_CNT_W-1:0] c_WDOG_LIMIT = 12'd4095;
    localparam logic [15:0]      c_CRC_POLY   = 16'h1021;
    localparam logic [15:0]      c_CRC_INIT   = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2
    } dec_state_t;

    // CRC-16-CCITT over one byte, MSB first
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ c_CRC_POLY;
            else                 c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_sync_decoder_if.sv
`default_nettype none
//==============================================================================
// Interface : vga_sync_decoder_if
// Brief     : VGA input stream and recovered pixel/geometry outputs.
// Rev       : 1.0  initial release
//==============================================================================
interface vga_sync_decoder_if;
    import vga_dec_pkg::*;

    logic               VGA_HS;
    logic               VGA_VS;
    logic [7:0]         VGA_COLOUR;
    logic               PIX_VALID;
    logic [9:0]         PIX_X;
    logic [9:0]         PIX_Y;
    logic [7:0]         PIX_COLOUR;
    logic               FRAME_START;
    logic [c_CNT_W-1:0] LINE_TOTAL;
    logic [c_CNT_W-1:0] FRAME_LINES;
    logic               LOCKED;
    logic               SYNC_ERR;
    logic [15:0]        FRAME_CRC;

    modport master (
        output VGA_HS, VGA_VS, VGA_COLOUR,
        input  PIX_VALID, PIX_X, PIX_Y, PIX_COLOUR, FRAME_START,
               LINE_TOTAL, FRAME_LINES, LOCKED, SYNC_ERR, FRAME_CRC
    );

    modport slave (
        input  VGA_HS, VGA_VS, VGA_COLOUR,
        output PIX_VALID, PIX_X, PIX_Y, PIX_COLOUR, FRAME_START,
               LINE_TOTAL, FRAME_LINES, LOCKED, SYNC_ERR, FRAME_CRC
    );
endinterface
`default_nettype wire

// File: rtl/vga_dec_sync_edge.sv
`default_nettype none
//==============================================================================
// Module : vga_dec_sync_edge
// Brief  : 2-FF synchroniser with leading/trailing edge detect for a sync pin.
// Rev    : 1.0  initial release
//==============================================================================
module vga_dec_sync_edge
    import vga_dec_pkg::*;
#(
    parameter bit SYNC_POL = 1'b0
) (
    input  wire  CLK,
    input  wire  RESET,
    input  wire  i_sig,
    output logic o_lead,
    output logic o_trail
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Resetting to the idle level keeps reset release from faking an edge
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_meta <= ~SYNC_POL;
            r_sync <= ~SYNC_POL;
            r_prev <= ~SYNC_POL;
        end else begin
            r_meta <= i_sig;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_lead  = (r_sync == SYNC_POL) && (r_prev != SYNC_POL);
    assign o_trail = (r_sync != SYNC_POL) && (r_prev == SYNC_POL);

endmodule
`default_nettype wire

// File: rtl/vga_sync_decoder.sv
`default_nettype none
//==============================================================================
// Module : vga_sync_decoder
// Brief  : Recovers pixel coordinates, strobe and frame geometry from VGA sync.
// Config : define VGA_DEC_CRC_EN to build the per-frame CRC-16 of active pixels.
// Rev    : 1.0  initial release
//==============================================================================
module vga_sync_decoder
    import vga_dec_pkg::*;
#(
    parameter int CLK_PER_PIXEL = 2,
    parameter int H_ACTIVE      = 640,
    parameter int H_BACK_PORCH  = 48,
    parameter int V_ACTIVE      = 480,
    parameter int V_BACK_PORCH  = 33,
    parameter bit SYNC_POL      = 1'b0
) (
    input wire                CLK,
    input wire                RESET,
    vga_sync_decoder_if.slave bus
);

    localparam logic [c_CNT_W-1:0] c_PH_LAST = c_CNT_W'(CLK_PER_PIXEL - 1);
    localparam logic [c_CNT_W-1:0] c_H_LO    = c_CNT_W'(H_BACK_PORCH);
    localparam logic [c_CNT_W-1:0] c_H_HI    = c_CNT_W'(H_BACK_PORCH + H_ACTIVE);
    localparam logic [c_CNT_W-1:0] c_V_LO    = c_CNT_W'(V_BACK_PORCH);
    localparam logic [c_CNT_W-1:0] c_V_HI    = c_CNT_W'(V_BACK_PORCH + V_ACTIVE);

    logic w_hs_lead, w_hs_trail, w_vs_lead, w_vs_trail;
    logic [7:0] r_col_d1, r_col_d2;
    logic [c_CNT_W-1:0] r_phase, r_hpos, r_vpos, r_line_cnt, r_fl_cnt;
    logic [c_CNT_W-1:0] w_phase_cur, w_hpos_cur, w_total_new, w_lines_new, w_x_full, w_y_full;
    logic w_tick, w_h_act, w_v_act, w_wdog, w_match, w_pix_valid, w_locked, w_lock_lost;
    dec_state_t r_state, w_state_nxt;

    logic               r_pix_valid, r_frame_start, r_sync_err;
    logic [9:0]         r_pix_x, r_pix_y;
    logic [7:0]         r_pix_col;
    logic [c_CNT_W-1:0] r_line_total, r_frame_lines, r_ref_total;

    vga_dec_sync_edge #(.SYNC_POL(SYNC_POL)) u_hs_edge (
        .CLK(CLK), .RESET(RESET), .i_sig(bus.VGA_HS), .o_lead(w_hs_lead), .o_trail(w_hs_trail)
    );

    vga_dec_sync_edge #(.SYNC_POL(SYNC_POL)) u_vs_edge (
        .CLK(CLK), .RESET(RESET), .i_sig(bus.VGA_VS), .o_lead(w_vs_lead), .o_trail(w_vs_trail)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_col_d1 <= '0;
            r_col_d2 <= '0;
        end else begin
            r_col_d1 <= bus.VGA_COLOUR;
            r_col_d2 <= r_col_d1;
        end
    end

    // The HS trailing-edge cycle is phase 0 of back-porch pixel 0
    always_comb begin
        w_phase_cur = w_hs_trail ? '0 : r_phase;
        w_hpos_cur  = w_hs_trail ? '0 : r_hpos;
        w_tick      = (w_phase_cur == c_PH_LAST);
        w_h_act     = (w_hpos_cur >= c_H_LO) && (w_hpos_cur < c_H_HI);
        w_v_act     = (r_vpos >= c_V_LO) && (r_vpos < c_V_HI);
        w_wdog      = (r_line_cnt == c_WDOG_LIMIT) && !w_hs_lead;
        w_pix_valid = w_tick && w_h_act && w_v_act && w_locked;
        w_x_full    = w_hpos_cur - c_H_LO;
        w_y_full    = r_vpos - c_V_LO;
        w_total_new = w_hs_lead ? r_line_cnt : r_line_total;
        w_lines_new = r_fl_cnt + (w_hs_lead ? 12'd1 : 12'd0);
        w_match     = (w_total_new == r_ref_total) && (w_lines_new == r_frame_lines);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_phase    <= '0;
            r_hpos     <= '0;
            r_vpos     <= '0;
            r_line_cnt <= '0;
            r_fl_cnt   <= '0;
        end else if (w_wdog) begin
            r_phase    <= '0;
            r_hpos     <= '0;
            r_vpos     <= '0;
            r_line_cnt <= '0;
            r_fl_cnt   <= '0;
        end else begin
            r_phase <= w_tick ? '0 : w_phase_cur + 1'b1;
            // hpos saturates so a lost HS can never wrap back into the active window
            r_hpos  <= (w_tick && (w_hpos_cur != '1)) ? w_hpos_cur + 1'b1 : w_hpos_cur;
            if (w_vs_trail)                      r_vpos <= '0;
            else if (w_hs_lead && r_vpos != '1)  r_vpos <= r_vpos + 1'b1;
            if (w_hs_lead)   r_line_cnt <= w_tick ? 12'd1 : 12'd0;
            else if (w_tick) r_line_cnt <= r_line_cnt + 1'b1;
            if (w_vs_lead)      r_fl_cnt <= '0;
            else if (w_hs_lead) r_fl_cnt <= r_fl_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) r_state <= ST_UNLOCKED;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_wdog) begin
            w_state_nxt = ST_UNLOCKED;
        end else if (w_vs_lead) begin
            case (r_state)
                ST_UNLOCKED: w_state_nxt = ST_ACQUIRE;
                ST_ACQUIRE:  w_state_nxt = w_match ? ST_LOCKED : ST_ACQUIRE;
                ST_LOCKED:   w_state_nxt = w_match ? ST_LOCKED : ST_ACQUIRE;
                default:     w_state_nxt = ST_UNLOCKED;
            endcase
        end
    end

    always_comb begin
        w_locked    = (r_state == ST_LOCKED);
        w_lock_lost = w_locked && (w_wdog || (w_vs_lead && !w_match));
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_pix_valid   <= 1'b0;
            r_pix_x       <= '0;
            r_pix_y       <= '0;
            r_pix_col     <= '0;
            r_frame_start <= 1'b0;
            r_sync_err    <= 1'b0;
            r_line_total  <= '0;
            r_frame_lines <= '0;
            r_ref_total   <= '0;
        end else begin
            r_pix_valid   <= w_pix_valid;
            r_frame_start <= w_vs_lead;
            r_sync_err    <= w_lock_lost;
            if (w_pix_valid) begin
                r_pix_x   <= w_x_full[9:0];
                r_pix_y   <= w_y_full[9:0];
                r_pix_col <= r_col_d2;
            end
            if (w_hs_lead) r_line_total <= r_line_cnt;
            if (w_vs_lead) begin
                r_frame_lines <= w_lines_new;
                r_ref_total   <= w_total_new;
            end
        end
    end

    assign bus.PIX_VALID   = r_pix_valid;
    assign bus.PIX_X       = r_pix_x;
    assign bus.PIX_Y       = r_pix_y;
    assign bus.PIX_COLOUR  = r_pix_col;
    assign bus.FRAME_START = r_frame_start;
    assign bus.SYNC_ERR    = r_sync_err;
    assign bus.LINE_TOTAL  = r_line_total;
    assign bus.FRAME_LINES = r_frame_lines;
    assign bus.LOCKED      = w_locked;

`ifdef VGA_DEC_CRC_EN
    logic [15:0] r_crc, r_frame_crc;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_crc       <= c_CRC_INIT;
            r_frame_crc <= '0;
        end else if (w_vs_lead) begin
            r_frame_crc <= r_crc;
            r_crc       <= c_CRC_INIT;
        end else if (w_pix_valid) begin
            r_crc <= crc16_byte(r_crc, r_col_d2);
        end
    end

    assign bus.FRAME_CRC = r_frame_crc;
`else
    assign bus.FRAME_CRC = 16'h0000;
`endif

endmodule
`default_nettype wire
